// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and the writeback source encoding.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EXEC = 2'd1,
        SRC_MEM  = 2'd2,
        SRC_DBG  = 2'd3
    } wb_src_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request groups plus the registered write-port outputs.
// The dbg group exists only when REGFILE_ARB_DBG_EN is defined.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic                  exec_valid;
    logic                  exec_ready;
    logic [REG_ADDR_W-1:0] exec_rd;
    logic [XLEN-1:0]       exec_val;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_val;

`ifdef REGFILE_ARB_DBG_EN
    logic                  dbg_valid;
    logic                  dbg_ready;
    logic [REG_ADDR_W-1:0] dbg_rd;
    logic [XLEN-1:0]       dbg_val;
`endif

    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       w_val;
    wb_src_t               wb_src;
    logic [3:0]            starve_cnt;

    modport master (
        output exec_valid, exec_rd, exec_val,
        input  exec_ready,
        output mem_valid, mem_rd, mem_val,
        input  mem_ready,
`ifdef REGFILE_ARB_DBG_EN
        output dbg_valid, dbg_rd, dbg_val,
        input  dbg_ready,
`endif
        input  rd_addr, w_val, wb_src, starve_cnt
    );

    modport slave (
        input  exec_valid, exec_rd, exec_val,
        output exec_ready,
        input  mem_valid, mem_rd, mem_val,
        output mem_ready,
`ifdef REGFILE_ARB_DBG_EN
        input  dbg_valid, dbg_rd, dbg_val,
        output dbg_ready,
`endif
        output rd_addr, w_val, wb_src, starve_cnt
    );

endinterface

// File: rtl/regfile_wb_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles a live exec request was denied;
// boost asserts once the count reaches STARVE_LIMIT, cleared on grant or idle.
module regfile_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       live,
    input  logic       granted,
    output logic [3:0] starve_cnt,
    output logic       boost
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (live && !granted) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    assign boost = (starve_cnt == LIMIT);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single-write-port arbiter (dbg > mem > exec, exec boosted after starvation); readies are
// combinational, winner lands on rd_addr/w_val one cycle later. REGFILE_ARB_DBG_EN adds dbg.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic                clock,
    input logic                reset,
    regfile_wb_arbiter_if.slave bus
);

    logic exec_live, mem_live, dbg_live;
    logic exec_null, mem_null;
    logic exec_win, mem_win, dbg_win;
    logic boost;

    assign exec_live = bus.exec_valid && (bus.exec_rd != '0);
    assign mem_live  = bus.mem_valid  && (bus.mem_rd  != '0);
    assign exec_null = bus.exec_valid && (bus.exec_rd == '0);
    assign mem_null  = bus.mem_valid  && (bus.mem_rd  == '0);

`ifdef REGFILE_ARB_DBG_EN
    logic dbg_null;
    assign dbg_live  = bus.dbg_valid && (bus.dbg_rd != '0);
    assign dbg_null  = bus.dbg_valid && (bus.dbg_rd == '0);
    assign bus.dbg_ready = !reset && (dbg_win || dbg_null);
`else
    assign dbg_live  = 1'b0;
`endif

    // A boosted exec only outranks mem; dbg keeps top priority regardless.
    assign dbg_win  = dbg_live;
    assign exec_win = exec_live && !dbg_live && (!mem_live || boost);
    assign mem_win  = mem_live && !dbg_live && !(exec_live && boost);

    assign bus.exec_ready = !reset && (exec_win || exec_null);
    assign bus.mem_ready  = !reset && (mem_win  || mem_null);

    regfile_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clock      (clock),
        .reset      (reset),
        .live       (exec_live),
        .granted    (exec_win),
        .starve_cnt (bus.starve_cnt),
        .boost      (boost)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.rd_addr <= '0;
            bus.w_val   <= '0;
            bus.wb_src  <= SRC_NONE;
`ifdef REGFILE_ARB_DBG_EN
        end else if (dbg_win) begin
            bus.rd_addr <= bus.dbg_rd;
            bus.w_val   <= bus.dbg_val;
            bus.wb_src  <= SRC_DBG;
`endif
        end else if (mem_win) begin
            bus.rd_addr <= bus.mem_rd;
            bus.w_val   <= bus.mem_val;
            bus.wb_src  <= SRC_MEM;
        end else if (exec_win) begin
            bus.rd_addr <= bus.exec_rd;
            bus.w_val   <= bus.exec_val;
            bus.wb_src  <= SRC_EXEC;
        end else begin
            bus.rd_addr <= '0;
            bus.w_val   <= '0;
            bus.wb_src  <= SRC_NONE;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with STARVE_LIMIT = 4.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        bus.exec_valid = 1'b0; bus.exec_rd = '0; bus.exec_val = '0;
        bus.mem_valid  = 1'b0; bus.mem_rd  = '0; bus.mem_val  = '0;
`ifdef REGFILE_ARB_DBG_EN
        bus.dbg_valid  = 1'b0; bus.dbg_rd  = '0; bus.dbg_val  = '0;
`endif
    endtask

    task automatic chk_out(input string tag, input logic [4:0] a, input logic [31:0] v,
                           input wb_src_t s);
        chk({tag, ".rd_addr"}, 32'(bus.rd_addr), 32'(a));
        chk({tag, ".w_val"},   bus.w_val, v);
        chk({tag, ".wb_src"},  32'(bus.wb_src), 32'(s));
    endtask

    initial begin
        idle_all();
        // Null request during reset must not be accepted.
        bus.exec_valid = 1'b1;
        #1;
        chk("rst_null_ready", 32'(bus.exec_ready), 32'd0);
        cyc();
        cyc();
        chk("rst_null_ready2", 32'(bus.exec_ready), 32'd0);
        chk_out("rst", 5'd0, 32'd0, SRC_NONE);
        chk("rst.starve", 32'(bus.starve_cnt), 32'd0);
        idle_all();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_out("idle", 5'd0, 32'd0, SRC_NONE);
        end

        // Single exec write.
        bus.exec_valid = 1'b1; bus.exec_rd = 5'd5; bus.exec_val = 32'hDEADBEEF;
        #1;
        chk("single.exec_ready", 32'(bus.exec_ready), 32'd1);
        cyc();
        chk_out("single", 5'd5, 32'hDEADBEEF, SRC_EXEC);
        idle_all();

        // Same rd from exec and mem: mem first, exec the cycle after.
        bus.exec_valid = 1'b1; bus.exec_rd = 5'd3; bus.exec_val = 32'h1111_1111;
        bus.mem_valid  = 1'b1; bus.mem_rd  = 5'd3; bus.mem_val  = 32'h2222_2222;
        #1;
        chk("clash.mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("clash.exec_ready", 32'(bus.exec_ready), 32'd0);
        cyc();
        chk_out("clash1", 5'd3, 32'h2222_2222, SRC_MEM);
        chk("clash1.starve", 32'(bus.starve_cnt), 32'd1);
        bus.mem_valid = 1'b0; bus.mem_rd = '0;
        #1;
        chk("clash2.exec_ready", 32'(bus.exec_ready), 32'd1);
        cyc();
        chk_out("clash2", 5'd3, 32'h1111_1111, SRC_EXEC);
        chk("clash2.starve", 32'(bus.starve_cnt), 32'd0);
        idle_all();

        // Starvation: mem every cycle, exec held at rd 7.
        bus.exec_valid = 1'b1; bus.exec_rd = 5'd7; bus.exec_val = 32'h0000_0777;
        bus.mem_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.mem_rd  = 5'(i);
            bus.mem_val = 32'(i * 16);
            #1;
            chk($sformatf("starve%0d.exec_ready", i), 32'(bus.exec_ready), (i == 5) ? 32'd1 : 32'd0);
            chk($sformatf("starve%0d.mem_ready", i), 32'(bus.mem_ready), (i == 5) ? 32'd0 : 32'd1);
            cyc();
            chk($sformatf("starve%0d.cnt", i), 32'(bus.starve_cnt), (i == 5) ? 32'd0 : 32'(i));
            chk($sformatf("starve%0d.rd_addr", i), 32'(bus.rd_addr), (i == 5) ? 32'd7 : 32'(i));
        end
        idle_all();

        // Null exec alongside live mem.
        bus.exec_valid = 1'b1; bus.exec_rd = 5'd0; bus.exec_val = 32'hFFFF_FFFF;
        bus.mem_valid  = 1'b1; bus.mem_rd  = 5'd9; bus.mem_val  = 32'h0000_0909;
        #1;
        chk("null.exec_ready", 32'(bus.exec_ready), 32'd1);
        chk("null.mem_ready", 32'(bus.mem_ready), 32'd1);
        cyc();
        chk_out("null", 5'd9, 32'h0000_0909, SRC_MEM);
        chk("null.starve", 32'(bus.starve_cnt), 32'd0);
        idle_all();

        // Reset with a write in flight and a new request pending.
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_val = 32'h0000_0444;
        cyc();
        chk_out("inflight", 5'd4, 32'h0000_0444, SRC_MEM);
        idle_all();
        bus.exec_valid = 1'b1; bus.exec_rd = 5'd6; bus.exec_val = 32'h0000_0666;
        reset = 1'b1;
        #1;
        chk("rstmid.exec_ready", 32'(bus.exec_ready), 32'd0);
        cyc();
        chk_out("rstmid", 5'd0, 32'd0, SRC_NONE);
        reset = 1'b0;
        idle_all();
        cyc();
        chk_out("after_rst", 5'd0, 32'd0, SRC_NONE);

`ifdef REGFILE_ARB_DBG_EN
        // Build exec up to boost, then dbg arrives: dbg wins, counter stays saturated.
        bus.exec_valid = 1'b1; bus.exec_rd = 5'd7; bus.exec_val = 32'h0000_0777;
        bus.mem_valid  = 1'b1; bus.mem_rd  = 5'd8; bus.mem_val  = 32'h0000_0888;
        for (int i = 0; i < 4; i++) cyc();
        chk("dbg.pre_starve", 32'(bus.starve_cnt), 32'd4);
        bus.dbg_valid = 1'b1; bus.dbg_rd = 5'd2; bus.dbg_val = 32'h0000_0222;
        #1;
        chk("dbg.dbg_ready", 32'(bus.dbg_ready), 32'd1);
        chk("dbg.exec_ready", 32'(bus.exec_ready), 32'd0);
        cyc();
        chk_out("dbg", 5'd2, 32'h0000_0222, SRC_DBG);
        chk("dbg.starve", 32'(bus.starve_cnt), 32'd4);
        bus.dbg_valid = 1'b0; bus.dbg_rd = '0;
        #1;
        chk("dbg2.exec_ready", 32'(bus.exec_ready), 32'd1);
        cyc();
        chk_out("dbg2", 5'd7, 32'h0000_0777, SRC_EXEC);
        idle_all();
        cyc();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 32×32 register file. It accepts writeback requests from the execute stage, the memory/load stage and an optional debug port. It grants at most one writer per cycle and drives the register file's single write port (`rd_addr`/`w_val`) from registers. A starvation counter keeps the lower-priority execute source from being locked out indefinitely.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive denied cycles after which exec gets one priority grant. Legal range 1..15.

Ports:
- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `exec_valid` in 1: execute-stage write request.
- `exec_ready` out 1: exec request accepted this cycle.
- `exec_rd` in 5: exec destination register.
- `exec_val` in 32: exec write data.
- `mem_valid` in 1: memory-stage write request.
- `mem_ready` out 1: mem request accepted this cycle.
- `mem_rd` in 5: mem destination register.
- `mem_val` in 32: mem write data.
- `dbg_valid`, `dbg_ready`, `dbg_rd`, `dbg_val`: same shape as the exec group; present only with `REGFILE_ARB_DBG_EN`.
- `rd_addr` out 5: register-file write address, registered; 0 means no write.
- `w_val` out 32: register-file write data, registered.
- `wb_src` out 2: source of the current `rd_addr`/`w_val` (`SRC_NONE`/`SRC_EXEC`/`SRC_MEM`/`SRC_DBG`), registered.
- `starve_cnt` out 4: current starvation count, for debug visibility.

## Operation
- A transfer occurs when `X_valid && X_ready`. Requesters hold valid, rd and val stable until accepted; valid must not drop before acceptance.
- Null requests (`X_rd == 0`) are accepted immediately with `X_ready = 1`. They consume no port slot, are never the winner and do not touch the starvation counter.
- Live requests have `X_rd != 0`. Priority order: dbg > mem > exec.
  - Exception: when `starve_cnt == STARVE_LIMIT` and exec is live, exec outranks mem. Debug still wins.
- `X_ready` is combinational from the valids/rds of this cycle: 1 for the single winner and for any null request, else 0.
- Winner latch: the winner's rd/val/src are registered into `rd_addr`/`w_val`/`wb_src` at the next edge. With no winner, the register-file outputs load `rd_addr = 0`, `w_val = 0`, `wb_src = SRC_NONE`.
- Starvation counter `starve_cnt` (saturating at `STARVE_LIMIT`):
  - Increments when exec is live and not granted.
  - Clears when exec is granted or exec is not live.
- Same rd from two sources in one cycle: only the winner is written. The loser writes one or more cycles later, so its value is the one that ends up in the register (program order is the requesters' concern).

## Timing
- Reset values: `rd_addr = 0`, `w_val = 0`, `wb_src = SRC_NONE`, `starve_cnt = 0`. During reset all `X_ready = 0`, including for null requests.
- Latency: a request accepted in cycle N appears on `rd_addr`/`w_val` in cycle N+1. The register file commits it at the end of N+1, and its same-cycle bypass covers reads in N+1.
- Throughput: one live write per cycle; null requests are unlimited.
- Reset asserted mid-operation:
  - Pending unaccepted requests are not granted.
  - The registered write in flight is replaced by `rd_addr = 0` at the reset edge.
  - No partial write.
- Continuous mem traffic with exec live: exec is denied `STARVE_LIMIT` cycles, then granted on cycle `STARVE_LIMIT + 1`. The counter then clears.

## Configuration
- `REGFILE_ARB_DBG_EN` defined:
  - The dbg port group exists with top priority.
  - `wb_src` can take `SRC_DBG`.
  - A live dbg request blocks the starvation boost and leaves `starve_cnt` saturated.
- Undefined: the dbg ports are absent, the arbiter is two-way and `SRC_DBG` is never produced.

## Structure
- Shared package `regfile_pkg` holds:
  - `XLEN = 32` and `REG_ADDR_W = 5`.
  - The 2-bit `wb_src_t` enum `SRC_NONE = 0`, `SRC_EXEC = 1`, `SRC_MEM = 2`, `SRC_DBG = 3`.
- One sub-module, `regfile_arb_starve_ctr`: the saturating counter plus boost flag. Inputs are live and granted; outputs are `starve_cnt` and `boost`.
- The grant logic and the output registers stay in the top module.

## Test plan
- After reset, with all valids low for 3 cycles: `rd_addr = 0`, `w_val = 0`, `wb_src = SRC_NONE` every cycle.
- Single exec request, `rd = 5`, `val = 0xDEADBEEF`: `exec_ready = 1` in cycle N; next cycle `rd_addr = 5`, `w_val = 0xDEADBEEF`, `wb_src = SRC_EXEC`.
- Exec `rd = 3` and mem `rd = 3` in the same cycle: mem wins (`rd_addr = 3`, `w_val = mem_val`); exec is written the following cycle with its own value.
- Mem valid every cycle (rd 1..), exec held at `rd = 7`, `STARVE_LIMIT = 4`:
  - `exec_ready` is 0 for 4 cycles, then 1 on the 5th.
  - `starve_cnt` goes 1,2,3,4 then returns to 0.
- Exec `rd = 0` together with mem `rd = 9`: both readies are 1 in the same cycle; the next cycle shows `rd_addr = 9` and `starve_cnt` stays 0.
- With `REGFILE_ARB_DBG_EN`, dbg `rd = 2` plus mem plus boosted exec: dbg is granted; exec is granted the next cycle once dbg drops. Also check that reset asserted in the request cycle yields `rd_addr = 0` next cycle.
